// File: rtl/sipo_deserializer.sv
// Serial-to-parallel word receiver: LSB-first stream framed by a start marker,
// delivered through a one-entry valid/ready holding register with error flags.
module sipo_deserializer #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q & ~data_ready;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = {serial_in, {(WIDTH-1){1'b0}}};
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (start) begin
                    // An early start drops the partial word and restarts on this bit.
                    ferr_d  = 1'b1;
                    shift_d = {serial_in, {(WIDTH-1){1'b0}}};
                    cnt_d   = CW'(1);
                end else begin
                    shift_d = {serial_in, shift_q[WIDTH-1:1]};
                    if (cnt_q == CW'(WIDTH-1)) begin
                        dout_d  = shift_d;
                        valid_d = 1'b1;
                        if (valid_q && !data_ready) begin
                            ovr_d = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign busy       = (state_q == SHIFT);
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: directed test-plan scenarios plus random traffic,
// every cycle compared against a bit-queue reference model.
module tb_sipo_deserializer;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         serial_in = 1'b0;
    logic         start = 1'b0;
    logic         data_ready = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    int errors = 0;
    int checks = 0;
    int busyCycles = 0;
    int ferrCycles = 0;
    int validCycles = 0;

    // Reference model: partial word kept as a queue of received bits.
    bit           mBits[$];
    logic [W-1:0] mDout = '0;
    logic         mValid = 1'b0;
    logic         mFerr = 1'b0;
    logic         mOvr = 1'b0;

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .serial_in(serial_in),
        .start(start),
        .data_out(data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .busy(busy),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("data_out", 32'(data_out), 32'(mDout));
        checkVal("data_valid", 32'(data_valid), 32'(mValid));
        checkVal("busy", 32'(busy), 32'(mBits.size() > 0));
        checkVal("frame_err", 32'(frame_err), 32'(mFerr));
        checkVal("overrun", 32'(overrun), 32'(mOvr));
    endtask

    task automatic modelStep(input logic s, input logic st, input logic rdy);
        logic         nextValid;
        logic [W-1:0] word;
        nextValid = mValid && !rdy;
        mFerr = 1'b0;
        if (st) begin
            if (mBits.size() > 0) mFerr = 1'b1;
            mBits.delete();
            mBits.push_back(s);
        end else if (mBits.size() > 0) begin
            mBits.push_back(s);
            if (mBits.size() == W) begin
                word = '0;
                for (int i = 0; i < W; i++) word[i] = mBits[i];
                if (mValid && !rdy) mOvr = 1'b1;
                mDout = word;
                nextValid = 1'b1;
                mBits.delete();
            end
        end
        mValid = nextValid;
    endtask

    // One clock: drive inputs, let the edge happen, then compare after it settles.
    task automatic applyStimulus(input logic s, input logic st, input logic rdy);
        serial_in  = s;
        start      = st;
        data_ready = rdy;
        @(posedge clk);
        modelStep(s, st, rdy);
        #1;
        checkOutput();
        if (busy === 1'b1) busyCycles++;
        if (frame_err === 1'b1) ferrCycles++;
        if (data_valid === 1'b1) validCycles++;
    endtask

    task automatic sendWord(input logic [W-1:0] w, input logic [W-1:0] rdyMask);
        for (int i = 0; i < W; i++) applyStimulus(w[i], i == 0, rdyMask[i]);
    endtask

    task automatic doReset();
        #3;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        mBits.delete();
        mDout = '0;
        mValid = 1'b0;
        mFerr = 1'b0;
        mOvr = 1'b0;
        checkOutput();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic st;
        #2;
        checkOutput();
        @(posedge clk);
        #1;
        checkOutput();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);

        busyCycles = 0;
        sendWord(12'hA5C, 12'h000);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkVal("single_busy_cycles", 32'(busyCycles), 32'd11);
        checkVal("single_data", 32'(data_out), 32'hA5C);
        checkVal("single_valid", 32'(data_valid), 32'd1);
        checkVal("single_overrun", 32'(overrun), 32'd0);

        ferrCycles = 0;
        validCycles = 0;
        sendWord(12'h001, 12'hFFF);
        checkVal("b2b_first", 32'(data_out), 32'h001);
        sendWord(12'hFFF, 12'hFFF);
        checkVal("b2b_second", 32'(data_out), 32'hFFF);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkVal("b2b_valid_cycles", 32'(validCycles), 32'd2);
        checkVal("b2b_no_frame_err", 32'(ferrCycles), 32'd0);

        sendWord(12'h123, 12'h000);
        sendWord(12'h456, 12'h000);
        checkVal("ovr_data", 32'(data_out), 32'h456);
        checkVal("ovr_flag", 32'(overrun), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkVal("ovr_consumed", 32'(data_valid), 32'd0);
        checkVal("ovr_sticky", 32'(overrun), 32'd1);

        doReset();
        sendWord(12'h0F0, 12'h000);
        sendWord(12'h70F, 12'h800);
        checkVal("simul_data", 32'(data_out), 32'h70F);
        checkVal("simul_valid", 32'(data_valid), 32'd1);
        checkVal("simul_overrun", 32'(overrun), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);

        ferrCycles = 0;
        validCycles = 0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        sendWord(12'h3C3, 12'h000);
        checkVal("early_ferr_pulses", 32'(ferrCycles), 32'd1);
        checkVal("early_valid_cycles", 32'(validCycles), 32'd1);
        checkVal("early_data", 32'(data_out), 32'h3C3);

        for (int i = 0; i < 7; i++) applyStimulus(1'(i), i == 0, 1'b0);
        checkVal("rst_pre_valid", 32'(data_valid), 32'd1);
        doReset();
        ferrCycles = 0;
        sendWord(12'h800, 12'h000);
        checkVal("rst_after_data", 32'(data_out), 32'h800);
        checkVal("rst_after_ferr", 32'(ferrCycles), 32'd0);

        for (int i = 0; i < 600; i++) begin
            if (mBits.size() > 0) st = ($urandom_range(0, 19) == 0);
            else st = ($urandom_range(0, 1) == 0);
            applyStimulus(1'($urandom), st, ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Receive-side counterpart of the 12-bit parallel-in/serial-out shifter in the spectrogram extractor. It samples a one-bit serial stream, LSB first, framed by a start marker on bit 0, and reassembles WIDTH-bit words. Completed words are presented through a one-entry holding register with a valid/ready handshake. It also reports framing errors and overruns. It sits between the serial link and the downstream spectrogram-bin consumer.

## Interface
- WIDTH, 12, word length in bits; legal range WIDTH >= 2.
- clk  input  1  system clock; all sampling on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- serial_in  input  1  serial data, one bit per clock, LSB first.
- start  input  1  high on the cycle serial_in carries bit 0 of a word.
- data_out  output  WIDTH  last completed word (holding register).
- data_valid  output  1  holding register contains an unconsumed word.
- data_ready  input  1  consumer accepts data_out when data_valid & data_ready.
- busy  output  1  a word is partially received (state SHIFT).
- frame_err  output  1  one-cycle pulse when a word is aborted by an early start.
- overrun  output  1  sticky; an unconsumed word was overwritten; cleared only by reset.

## Operation
- Reset (rst_n low, asynchronous): state IDLE, shift register 0, bit counter 0, data_out 0, data_valid 0, busy 0, frame_err 0, overrun 0. A partial word is discarded.
- Shift register shifts right; each new bit enters at bit WIDTH-1. After WIDTH samples, the first-sampled bit is at bit 0.
- Bit counter is $clog2(WIDTH) bits wide and counts sampled bits of the current word.
- IDLE:
  - start=0: serial_in is ignored.
  - start=1: sample bit 0, counter=1, go to SHIFT.
- SHIFT, start=0: sample bit and increment counter.
  - When the sampled bit is bit WIDTH-1 (counter == WIDTH-1 before the edge), load {serial_in, shift[WIDTH-1:1]} into data_out, set data_valid, clear counter, go to IDLE.
- SHIFT, start=1 (on any bit, including the final bit): abort the partial word, which is never delivered. Pulse frame_err. Treat the current bit as bit 0 of a new word: counter=1, stay in SHIFT.
- Handshake: data_valid & data_ready at an edge consumes the word. data_valid falls unless a new word loads on the same edge.
- Word completion on an edge:
  - data_valid=0: load the word, data_valid=1.
  - data_valid=1 and data_ready=1: old word consumed, new word loaded, data_valid stays 1, no overrun.
  - data_valid=1 and data_ready=0: new word overwrites data_out, data_valid stays 1, overrun set to 1.
- data_out is stable while data_valid=1 and no completion occurs.
- busy = (state == SHIFT).

## Timing
- Latency: start sampled at edge t0; last bit at edge t0+WIDTH-1. data_out and data_valid are updated by edge t0+WIDTH-1 and visible in the following cycle.
- Back-to-back: start is accepted on the cycle immediately after the completion edge. There are zero idle cycles between words, giving sustained throughput of one word per WIDTH cycles.
- frame_err is high for exactly the cycle after the aborting edge.
- All outputs are registered; no combinational path from inputs to outputs.
- rst_n deassertion takes effect at the next rising edge; no sampling happens while rst_n is low.

## Test plan
- **Single word:** reset, then send 0xA5C LSB first with start on bit 0 and data_ready=0. Required: data_valid rises after the 12th edge; data_out=0xA5C; busy high for exactly 11 cycles; overrun=0.
- **Back-to-back:** send 0x001 then 0xFFF back-to-back with data_ready=1 throughout. Required: data_valid high one cycle for each word, 12 cycles apart, with data_out=0x001 then 0xFFF; frame_err never asserted.
- **Overrun:** hold data_ready=0 and send 0x123 then 0x456. Required: data_out=0x456, data_valid=1, overrun=1. Raise data_ready for one cycle: data_valid=0, overrun stays 1.
- **Simultaneous consume and complete:** data_valid=1 holding 0x0F0; complete word 0x70F on the same edge where data_ready=1. Required: data_out=0x70F, data_valid=1, overrun=0.
- **Early start:** assert start again on bit 5 of a word, then send 12 clean bits of 0x3C3. Required: one frame_err pulse, the aborted word is never delivered, and data_out=0x3C3 after the 12th bit counted from the new start.
- **Reset mid-word:** pull rst_n low after 7 bits with data_valid=1. Required: all outputs 0 immediately (asynchronous). After release, a full word 0x800 is received correctly with no frame_err.
